// File: rtl/sdrc_pkg.sv
// Shared definitions for the SDRAM-controller stand-in: user-interface widths,
// command encodings and responder FSM states.
package sdrc_pkg;

    localparam int unsigned BankW     = 2;
    localparam int unsigned RowW      = 11;
    localparam int unsigned ColW      = 8;
    localparam int unsigned UserAddrW = BankW + RowW + ColW;
    localparam int unsigned UserDataW = 32;
    localparam int unsigned UserLenW  = 8;
    localparam int unsigned UserDqmW  = UserDataW / 8;
    localparam int unsigned BeatW     = UserLenW + 1;

    typedef enum logic [2:0] {
        CMD_LOAD_MODE = 3'b000,
        CMD_REFRESH   = 3'b001,
        CMD_PRECHARGE = 3'b010,
        CMD_ACTIVATE  = 3'b011,
        CMD_WRITE     = 3'b100,
        CMD_READ      = 3'b101,
        CMD_NOP6      = 3'b110,
        CMD_NOP7      = 3'b111
    } sdrc_cmd_e;

    typedef struct packed {
        logic [BankW-1:0] bank;
        logic [RowW-1:0]  row;
        logic [ColW-1:0]  col;
    } sdrc_addr_t;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_WR_WAIT,
        ST_WR,
        ST_RD_WAIT,
        ST_RD,
        ST_REFRESH,
        ST_ACK
    } sdrc_state_e;

endpackage

// File: rtl/sdrc_bram.sv
// Single-port word store with byte write-enables and a registered, enabled read port.
module sdrc_bram #(
    parameter int unsigned AddrW = 10,
    parameter int unsigned DataW = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [AddrW-1:0]     addr,
    input  logic                 re,
    input  logic [DataW/8-1:0]   we,
    input  logic [DataW-1:0]     wdata,
    output logic [DataW-1:0]     rdata
);

    localparam int unsigned Depth = 2 ** AddrW;
    localparam int unsigned ByteN = DataW / 8;

    logic [DataW-1:0] mem [Depth];
    logic [DataW-1:0] rdata_q;
    logic [DataW-1:0] rdata_d;

    always_ff @(posedge clk) begin
        for (int b = 0; b < int'(ByteN); b++) begin
            if (we[b]) begin
                mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    // Read register only updates on a read, so it holds the last beat otherwise.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/sdrc_responder.sv
// Block-RAM-backed responder for the SDRAM controller user interface: init handshake,
// bursts with byte masks, refresh and acknowledge with programmable latencies.
module sdrc_responder
    import sdrc_pkg::*;
#(
    parameter int unsigned MemAddressBitWidth = 10,
    parameter int unsigned InitCycles         = 16,
    parameter int unsigned ReadLatency        = 4,
    parameter int unsigned WriteDataDelay     = 0,
    parameter int unsigned RefreshCycles      = 8
) (
    input  logic                 I_sdrc_clk,
    input  logic                 I_sdrc_rst_n,
    input  logic                 I_sdrc_cmd_en,
    input  logic [2:0]           I_sdrc_cmd,
    input  logic [UserAddrW-1:0] I_sdrc_addr,
    input  logic [UserLenW-1:0]  I_sdrc_data_len,
    input  logic [UserDqmW-1:0]  I_sdrc_dqm,
    input  logic [UserDataW-1:0] I_sdrc_data,
    input  logic                 I_sdrc_precharge_ctrl,
    input  logic                 I_sdram_power_down,
    input  logic                 I_sdram_selfrefresh,
    output logic [UserDataW-1:0] O_sdrc_data,
    output logic                 O_sdrc_init_done,
    output logic                 O_sdrc_cmd_ack
);

    localparam int unsigned AW     = MemAddressBitWidth;
    localparam int unsigned CntMax = (InitCycles > RefreshCycles)
                                     ? ((InitCycles > 16) ? InitCycles : 16)
                                     : ((RefreshCycles > 16) ? RefreshCycles : 16);
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    sdrc_state_e           state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [AW-1:0]         addr_q, addr_d;
    logic [BeatW-1:0]      beats_q, beats_d;
    logic                  init_done_q, init_done_d;
    logic                  ack_q, ack_d;

    logic [AW-1:0]         acc_addr_c;
    logic [AW-1:0]         mem_addr_c;
    logic                  mem_re_c;
    logic [UserDqmW-1:0]   mem_we_c;
    logic                  unused_c;

    assign acc_addr_c = I_sdrc_addr[AW-1:0];
    assign unused_c   = ^{I_sdrc_addr, I_sdrc_precharge_ctrl, I_sdram_power_down,
                          I_sdram_selfrefresh};

    // beats_q counts beats still to be issued; a zero-delay case handles beat 0 at accept.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        beats_d     = beats_q;
        init_done_d = init_done_q;
        ack_d       = 1'b0;
        mem_addr_c  = addr_q;
        mem_re_c    = 1'b0;
        mem_we_c    = '0;

        unique case (state_q)
            ST_INIT: begin
                if (cnt_q == CntW'(InitCycles - 1)) begin
                    state_d     = ST_IDLE;
                    init_done_d = 1'b1;
                    cnt_d       = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            ST_IDLE: begin
                if (I_sdrc_cmd_en) begin
                    addr_d  = acc_addr_c;
                    beats_d = BeatW'(I_sdrc_data_len) + BeatW'(1);
                    cnt_d   = CntW'(1);
                    case (sdrc_cmd_e'(I_sdrc_cmd))
                        CMD_WRITE: begin
                            if (WriteDataDelay == 0) begin
                                mem_addr_c = acc_addr_c;
                                mem_we_c   = ~I_sdrc_dqm;
                                addr_d     = acc_addr_c + AW'(1);
                                beats_d    = BeatW'(I_sdrc_data_len);
                                if (I_sdrc_data_len == '0) begin
                                    state_d = ST_ACK;
                                    ack_d   = 1'b1;
                                end else begin
                                    state_d = ST_WR;
                                end
                            end else if (WriteDataDelay == 1) begin
                                state_d = ST_WR;
                            end else begin
                                state_d = ST_WR_WAIT;
                            end
                        end
                        CMD_READ: begin
                            if (ReadLatency == 1) begin
                                mem_addr_c = acc_addr_c;
                                mem_re_c   = 1'b1;
                                addr_d     = acc_addr_c + AW'(1);
                                beats_d    = BeatW'(I_sdrc_data_len);
                                state_d    = ST_RD;
                            end else if (ReadLatency == 2) begin
                                state_d = ST_RD;
                            end else begin
                                state_d = ST_RD_WAIT;
                            end
                        end
                        CMD_REFRESH: begin
                            if (RefreshCycles == 1) begin
                                state_d = ST_ACK;
                                ack_d   = 1'b1;
                            end else begin
                                state_d = ST_REFRESH;
                            end
                        end
                        default: begin
                            state_d = ST_ACK;
                            ack_d   = 1'b1;
                        end
                    endcase
                end
            end
            ST_WR_WAIT: begin
                if (cnt_q == CntW'(WriteDataDelay - 1)) begin
                    state_d = ST_WR;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            ST_WR: begin
                mem_addr_c = addr_q;
                mem_we_c   = ~I_sdrc_dqm;
                addr_d     = addr_q + AW'(1);
                if (beats_q == BeatW'(1)) begin
                    state_d = ST_ACK;
                    ack_d   = 1'b1;
                end else begin
                    beats_d = beats_q - BeatW'(1);
                end
            end
            ST_RD_WAIT: begin
                if (cnt_q == CntW'(ReadLatency - 2)) begin
                    state_d = ST_RD;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            ST_RD: begin
                // One trailing cycle after the last issue lets the final beat leave the store.
                if (beats_q != '0) begin
                    mem_addr_c = addr_q;
                    mem_re_c   = 1'b1;
                    addr_d     = addr_q + AW'(1);
                    beats_d    = beats_q - BeatW'(1);
                end else begin
                    state_d = ST_ACK;
                    ack_d   = 1'b1;
                end
            end
            ST_REFRESH: begin
                if (cnt_q == CntW'(RefreshCycles - 1)) begin
                    state_d = ST_ACK;
                    ack_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge I_sdrc_clk or negedge I_sdrc_rst_n) begin
        if (!I_sdrc_rst_n) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            addr_q      <= '0;
            beats_q     <= '0;
            init_done_q <= 1'b0;
            ack_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            beats_q     <= beats_d;
            init_done_q <= init_done_d;
            ack_q       <= ack_d;
        end
    end

    sdrc_bram #(
        .AddrW (AW),
        .DataW (UserDataW)
    ) u_bram (
        .clk   (I_sdrc_clk),
        .rst_n (I_sdrc_rst_n),
        .addr  (mem_addr_c),
        .re    (mem_re_c),
        .we    (mem_we_c),
        .wdata (I_sdrc_data),
        .rdata (O_sdrc_data)
    );

    assign O_sdrc_init_done = init_done_q;
    assign O_sdrc_cmd_ack   = ack_q;

endmodule

// File: tb/tb_sdrc_responder.sv
// Directed bench for sdrc_responder: init, bursts, byte masks, wrap/alias, refresh, reset abort.
module tb_sdrc_responder;

    localparam int ReadLat = 4;

    logic        clk;
    logic        rst_n;
    logic        cmd_en;
    logic [2:0]  cmd;
    logic [20:0] addr;
    logic [7:0]  data_len;
    logic [3:0]  dqm;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        init_done;
    logic        ack;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    logic [31:0] wbuf [16];
    logic [3:0]  mbuf [16];
    logic [31:0] ebuf [16];

    sdrc_responder dut (
        .I_sdrc_clk            (clk),
        .I_sdrc_rst_n          (rst_n),
        .I_sdrc_cmd_en         (cmd_en),
        .I_sdrc_cmd            (cmd),
        .I_sdrc_addr           (addr),
        .I_sdrc_data_len       (data_len),
        .I_sdrc_dqm            (dqm),
        .I_sdrc_data           (wdata),
        .I_sdrc_precharge_ctrl (1'b0),
        .I_sdram_power_down    (1'b0),
        .I_sdram_selfrefresh   (1'b0),
        .O_sdrc_data           (rdata),
        .O_sdrc_init_done      (init_done),
        .O_sdrc_cmd_ack        (ack)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [20:0] a, input logic [7:0] len, input string tag);
        cmd_en   = 1'b1;
        cmd      = 3'b100;
        addr     = a;
        data_len = len;
        wdata    = wbuf[0];
        dqm      = mbuf[0];
        step();
        cmd_en = 1'b0;
        for (int k = 1; k <= int'(len); k++) begin
            wdata = wbuf[k];
            dqm   = mbuf[k];
            step();
        end
        check($sformatf("%s ack", tag), {31'd0, ack}, 32'd1);
        dqm = 4'hF;
        step();
        check($sformatf("%s ack_end", tag), {31'd0, ack}, 32'd0);
    endtask

    task automatic do_read(input logic [20:0] a, input logic [7:0] len, input string tag);
        cmd_en   = 1'b1;
        cmd      = 3'b101;
        addr     = a;
        data_len = len;
        step();
        cmd_en = 1'b0;
        for (int i = 1; i < ReadLat; i++) step();
        for (int k = 0; k <= int'(len); k++) begin
            check($sformatf("%s beat%0d", tag, k), rdata, ebuf[k]);
            check($sformatf("%s ack_early%0d", tag, k), {31'd0, ack}, 32'd0);
            step();
        end
        check($sformatf("%s ack", tag), {31'd0, ack}, 32'd1);
        step();
        check($sformatf("%s ack_end", tag), {31'd0, ack}, 32'd0);
    endtask

    task automatic do_simple(input logic [2:0] c, input string tag);
        cmd_en = 1'b1;
        cmd    = c;
        step();
        cmd_en = 1'b0;
        check($sformatf("%s ack", tag), {31'd0, ack}, 32'd1);
        step();
        check($sformatf("%s ack_end", tag), {31'd0, ack}, 32'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        cmd_en   = 1'b0;
        cmd      = 3'b110;
        addr     = '0;
        data_len = '0;
        dqm      = 4'hF;
        wdata    = '0;
        repeat (3) step();
        check("rst init_done", {31'd0, init_done}, 32'd0);
        check("rst ack", {31'd0, ack}, 32'd0);
        check("rst data", rdata, 32'd0);

        // Init with a read strobe held high the whole time
        cmd_en = 1'b1;
        cmd    = 3'b101;
        addr   = 21'h10;
        rst_n  = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            step();
            check($sformatf("init ack c%0d", i), {31'd0, ack}, 32'd0);
        end
        check("init_done c15", {31'd0, init_done}, 32'd0);
        step();
        cmd_en = 1'b0;
        check("init_done c16", {31'd0, init_done}, 32'd1);
        check("init ack c16", {31'd0, ack}, 32'd0);
        step();
        check("init ack c17", {31'd0, ack}, 32'd0);
        check("init data", rdata, 32'd0);

        // Burst write then read-back
        for (int k = 0; k < 4; k++) begin
            wbuf[k] = 32'hA0 + 32'(k);
            mbuf[k] = 4'h0;
            ebuf[k] = 32'hA0 + 32'(k);
        end
        do_write(21'h10, 8'd3, "wr10");
        do_read(21'h10, 8'd3, "rd10");

        // Byte mask
        wbuf[0] = 32'h11223344;
        mbuf[0] = 4'h0;
        do_write(21'h20, 8'd0, "wr20a");
        wbuf[0] = 32'hFFFFFFFF;
        mbuf[0] = 4'b0101;
        do_write(21'h20, 8'd0, "wr20b");
        ebuf[0] = 32'hFF22FF44;
        do_read(21'h20, 8'd0, "rd20");

        // Wrap and alias
        wbuf[0] = 32'd1;
        wbuf[1] = 32'd2;
        mbuf[0] = 4'h0;
        mbuf[1] = 4'h0;
        do_write(21'h3FF, 8'd1, "wrwrap");
        ebuf[0] = 32'd1;
        ebuf[1] = 32'd2;
        do_read(21'h3FF, 8'd1, "rdwrap");
        ebuf[0] = 32'd2;
        do_read(21'h400, 8'd0, "rdalias");

        // Non-memory commands acknowledge one cycle after accept
        do_simple(3'b011, "activate");
        do_simple(3'b111, "nop");
        do_simple(3'b000, "loadmode");

        // Refresh with an ignored read strobe at T0+3
        cmd_en = 1'b1;
        cmd    = 3'b001;
        step();
        cmd_en = 1'b0;
        check("ref ack t1", {31'd0, ack}, 32'd0);
        step();
        check("ref ack t2", {31'd0, ack}, 32'd0);
        step();
        cmd_en   = 1'b1;
        cmd      = 3'b101;
        addr     = 21'h10;
        data_len = 8'd0;
        check("ref ack t3", {31'd0, ack}, 32'd0);
        step();
        cmd_en = 1'b0;
        for (int t = 4; t < 8; t++) begin
            check($sformatf("ref ack t%0d", t), {31'd0, ack}, 32'd0);
            check($sformatf("ref data t%0d", t), rdata, 32'd2);
            step();
        end
        check("ref ack t8", {31'd0, ack}, 32'd1);
        check("ref data t8", rdata, 32'd2);
        for (int t = 9; t < 15; t++) begin
            step();
            check($sformatf("ref ack t%0d", t), {31'd0, ack}, 32'd0);
            check($sformatf("ref data t%0d", t), rdata, 32'd2);
        end

        // Reset during a long read burst
        cmd_en   = 1'b1;
        cmd      = 3'b101;
        addr     = 21'h10;
        data_len = 8'd15;
        step();
        cmd_en = 1'b0;
        for (int i = 1; i < ReadLat; i++) step();
        for (int k = 0; k < 4; k++) begin
            check($sformatf("rdlong beat%0d", k), rdata, 32'hA0 + 32'(k));
            step();
        end
        step();
        rst_n = 1'b0;
        #1;
        check("abort ack", {31'd0, ack}, 32'd0);
        check("abort init_done", {31'd0, init_done}, 32'd0);
        check("abort data", rdata, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        repeat (15) step();
        check("reinit c15", {31'd0, init_done}, 32'd0);
        step();
        check("reinit c16", {31'd0, init_done}, 32'd1);
        step();
        for (int k = 0; k < 4; k++) ebuf[k] = 32'hA0 + 32'(k);
        do_read(21'h10, 8'd3, "rdkeep10");
        ebuf[0] = 32'hFF22FF44;
        do_read(21'h20, 8'd0, "rdkeep20");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
